// File: rtl/axicb_mst_switch_wr.sv
// axicb_mst_switch_wr: slave-side AXI write switch merging 4 masters into one slave.
// Define AXICB_MST_SWITCH_WR_AW_REGSLICE_EN to register the slave AW channel.
module axicb_mst_switch_wr #(
    parameter int AXI_ADDR_W = 8,
    parameter int AXI_ID_W = 8,
    parameter int MST_NB = 4,
    parameter logic [AXI_ID_W-1:0] MST0_ID_MASK = 'h10,
    parameter logic [AXI_ID_W-1:0] MST1_ID_MASK = 'h20,
    parameter logic [AXI_ID_W-1:0] MST2_ID_MASK = 'h40,
    parameter logic [AXI_ID_W-1:0] MST3_ID_MASK = 'h80,
    parameter int WFIFO_ADDR_W = 3,
    parameter int AWCH_W = 8,
    parameter int WCH_W = 8,
    parameter int BCH_W = 8
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic [MST_NB-1:0]        i_awvalid,
    output logic [MST_NB-1:0]        i_awready,
    input  logic [MST_NB*AWCH_W-1:0] i_awch,
    input  logic [MST_NB-1:0]        i_wvalid,
    output logic [MST_NB-1:0]        i_wready,
    input  logic [MST_NB-1:0]        i_wlast,
    input  logic [MST_NB*WCH_W-1:0]  i_wch,
    output logic [MST_NB-1:0]        i_bvalid,
    input  logic [MST_NB-1:0]        i_bready,
    output logic [BCH_W-1:0]         i_bch,
    output logic                     o_awvalid,
    input  logic                     o_awready,
    output logic [AWCH_W-1:0]        o_awch,
    output logic                     o_wvalid,
    input  logic                     o_wready,
    output logic                     o_wlast,
    output logic [WCH_W-1:0]         o_wch,
    input  logic                     o_bvalid,
    output logic                     o_bready,
    input  logic [BCH_W-1:0]         o_bch
);

    localparam int MST_IW = $clog2(MST_NB);
    localparam int DEPTH = 1 << WFIFO_ADDR_W;
    localparam logic [WFIFO_ADDR_W:0] PTR_ONE = 1;
    localparam logic [AXI_ID_W-1:0] ID_MASK [4] =
        '{MST0_ID_MASK, MST1_ID_MASK, MST2_ID_MASK, MST3_ID_MASK};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t state_q, state_d;
    logic [MST_NB-1:0] grant_q, grant_d;
    logic [MST_IW-1:0] gidx_q, gidx_d;
    logic [MST_IW-1:0] last_q, last_d;

    logic [MST_NB-1:0] rr_grant;
    logic [MST_IW-1:0] rr_idx, rr_cand;
    logic rr_found;

    logic aw_sel_valid;
    logic [AWCH_W-1:0] aw_sel_ch;
    logic aw_rdy, push, pop;

    logic [MST_NB-1:0] fifo_q [DEPTH];
    logic [MST_NB-1:0] fifo_d [DEPTH];
    logic [WFIFO_ADDR_W:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic fifo_full, fifo_empty;
    logic [MST_NB-1:0] head;
    logic [MST_IW-1:0] head_idx;

    logic [MST_NB-1:0] bsel;
    logic bhit;

    // Round-robin search begins just after the last master that handshaked
    always_comb begin
        rr_grant = '0;
        rr_idx = last_q;
        rr_cand = last_q;
        rr_found = 1'b0;
        for (int k = 1; k <= MST_NB; k++) begin
            rr_cand = MST_IW'((int'(last_q) + k) % MST_NB);
            if (!rr_found && i_awvalid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx = rr_cand;
            end
        end
        rr_grant[rr_idx] = rr_found;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d = gidx_q;
        last_d = last_q;
        unique case (state_q)
            IDLE: begin
                if (rr_found && !fifo_full) begin
                    grant_d = rr_grant;
                    gidx_d = rr_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (push) begin
                    last_d = gidx_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign aw_sel_valid = i_awvalid[gidx_q];
    assign aw_sel_ch = i_awch[gidx_q*AWCH_W +: AWCH_W];
    assign push = (state_q == GRANT) && aw_sel_valid && aw_rdy;
    assign i_awready = ((state_q == GRANT) && aw_rdy) ? grant_q : '0;

`ifdef AXICB_MST_SWITCH_WR_AW_REGSLICE_EN
    logic slv_q, slv_d;
    logic [AWCH_W-1:0] sch_q, sch_d;

    assign aw_rdy = !slv_q || o_awready;

    always_comb begin
        slv_d = push || (slv_q && !o_awready);
        sch_d = push ? aw_sel_ch : sch_q;
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            slv_q <= 1'b0;
            sch_q <= '0;
        end else begin
            slv_q <= slv_d;
            sch_q <= sch_d;
        end
    end

    assign o_awvalid = slv_q;
    assign o_awch = sch_q;
`else
    assign aw_rdy = o_awready;
    assign o_awvalid = (state_q == GRANT) && aw_sel_valid;
    assign o_awch = aw_sel_ch;
`endif

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full = (wptr_q[WFIFO_ADDR_W] != rptr_q[WFIFO_ADDR_W]) &&
                       (wptr_q[WFIFO_ADDR_W-1:0] == rptr_q[WFIFO_ADDR_W-1:0]);
    assign head = fifo_empty ? '0 : fifo_q[rptr_q[WFIFO_ADDR_W-1:0]];

    always_comb begin
        head_idx = '0;
        for (int m = 0; m < MST_NB; m++) begin
            if (head[m]) head_idx = MST_IW'(m);
        end
    end

    assign o_wvalid = |(i_wvalid & head);
    assign o_wlast = |(i_wlast & head);
    assign o_wch = fifo_empty ? '0 : i_wch[head_idx*WCH_W +: WCH_W];
    assign i_wready = o_wready ? head : '0;
    assign pop = o_wvalid && o_wready && o_wlast;

    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wptr_q[WFIFO_ADDR_W-1:0]] = grant_q;
        wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = pop ? rptr_q + PTR_ONE : rptr_q;
    end

    // Lowest matching master wins when ID masks overlap
    always_comb begin
        bsel = '0;
        bhit = 1'b0;
        for (int m = MST_NB - 1; m >= 0; m--) begin
            if ((o_bch[AXI_ID_W-1:0] & ID_MASK[m]) == ID_MASK[m]) begin
                bsel = '0;
                bsel[m] = 1'b1;
                bhit = 1'b1;
            end
        end
    end

    assign i_bvalid = o_bvalid ? bsel : '0;
    assign o_bready = bhit ? |(i_bready & bsel) : 1'b1;
    assign i_bch = o_bch;

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q <= '0;
            last_q <= MST_IW'(MST_NB - 1);
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q <= gidx_d;
            last_q <= last_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fifo_q <= fifo_d;
        end
    end

endmodule
